// File: rtl/spi_boot_pkg.sv
// spi_boot_pkg: shared command codes, terminator and FSM encoding
// for the SPI boot loader controller.
package spi_boot_pkg;

  localparam logic [7:0]  CMD_STATUS = 8'h00;
  localparam logic [7:0]  CMD_READ   = 8'h01;
  localparam logic [7:0]  CMD_WRITE  = 8'h02;
  localparam logic [31:0] BOOT_TERM  = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WR_COL,
    S_WR_BUS,
    S_RD_COL,
    S_RD_BUS,
    S_ST_SEND,
    S_DRAIN
  } state_t;

  function automatic logic is_col(state_t s);
    return (s == S_WR_COL) || (s == S_RD_COL) ||
           (s == S_ST_SEND);
  endfunction

endpackage

// File: rtl/spi_boot_ctrl_if.sv
// spi_boot_ctrl_if: IMEM bus between the boot controller (master)
// and the memory (slave).
interface spi_boot_ctrl_if #(
  parameter int ADR_W = 32
);

  logic             o_mem_cyc;
  logic             o_mem_we;
  logic [ADR_W-1:0] o_mem_adr;
  logic [31:0]      o_mem_dat;
  logic [31:0]      i_mem_rdt;
  logic             i_mem_ack;

  modport master (
    output o_mem_cyc, o_mem_we,
    output o_mem_adr, o_mem_dat,
    input  i_mem_rdt, i_mem_ack
  );

  modport slave (
    input  o_mem_cyc, o_mem_we,
    input  o_mem_adr, o_mem_dat,
    output i_mem_rdt, i_mem_ack
  );

endinterface

// File: rtl/spi_word_asm.sv
// spi_word_asm: 4-byte LSB-first word assembler and tx serialiser
// sharing one byte counter.
module spi_word_asm (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        acc,
  input  logic [7:0]  rx_data,
  input  logic        load,
  input  logic [31:0] load_word,
  output logic [31:0] word,
  output logic [31:0] word_nxt,
  output logic        done,
  output logic [7:0]  tx_data
);

  logic [1:0]  cnt;
  logic [31:0] rx_q;
  logic [31:0] tx_q;

  assign word_nxt = {rx_data, rx_q[31:8]};
  assign done     = acc && (cnt == 2'd3);
  assign word     = rx_q;
  assign tx_data  = tx_q[7:0];

  // byte counter, rx shift-in and tx shift-out
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= 2'd0;
      rx_q <= '0;
      tx_q <= '0;
    end else begin
      if (clr) begin
        cnt <= 2'd0;
      end else if (acc) begin
        cnt  <= cnt + 2'd1;
        rx_q <= word_nxt;
      end
      if (load) begin
        tx_q <= load_word;
      end else if (acc) begin
        tx_q <= {8'h00, tx_q[31:8]};
      end
    end
  end

endmodule

// File: rtl/spi_boot_ctrl.sv
// spi_boot_ctrl: SPI command slave that loads IMEM and reports status.
// Define SPI_BOOT_READBACK_EN to enable the 0x01 IMEM read-back command.
module spi_boot_ctrl
  import spi_boot_pkg::*;
#(
  parameter int IMEM_WORDS = 1024,
  parameter int ADR_W      = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_csn,
  input  logic            i_rx_valid,
  input  logic [7:0]      i_rx_data,
  output logic [7:0]      o_tx_data,
  spi_boot_ctrl_if.master bus,
  input  logic [31:0]     i_status,
  output logic            o_prog,
  output logic            o_boot_done,
  output logic            o_ovr,
  output logic [15:0]     o_word_cnt
);

  state_t      state;
  state_t      state_nxt;
  logic        csn_q;
  logic        csn_fall;
  logic [31:0] word_idx;
  logic [15:0] word_cnt;
  logic        ovr;
  logic        boot_done;
  logic        prog;
  logic        idx_full;
  logic        rx_cmd;

  logic        acc;
  logic        asm_clr;
  logic        asm_done;
  logic        tx_load;
  logic [31:0] tx_word;
  logic [31:0] asm_word;
  logic [31:0] asm_word_nxt;

  logic        wr_dec;
  logic        term_hit;
  logic        full_hit;
  logic        drop;
  logic        wr_ack;

  assign csn_fall = csn_q && !i_csn;
  assign idx_full = word_idx >= 32'(IMEM_WORDS);
  assign rx_cmd   = (state == S_CMD) && i_rx_valid && !i_csn;
  assign acc      = i_rx_valid && !i_csn && is_col(state);

  assign o_prog      = prog;
  assign o_boot_done = boot_done;
  assign o_ovr       = ovr;
  assign o_word_cnt  = word_cnt;

`ifndef SPI_BOOT_READBACK_EN
  logic unused_rdt;
  assign unused_rdt = ^bus.i_mem_rdt;
`endif

  spi_word_asm u_asm (
    .clk       (i_clk),
    .rst       (i_rst),
    .clr       (asm_clr),
    .acc       (acc),
    .rx_data   (i_rx_data),
    .load      (tx_load),
    .load_word (tx_word),
    .word      (asm_word),
    .word_nxt  (asm_word_nxt),
    .done      (asm_done),
    .tx_data   (o_tx_data)
  );

  // state register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // next-state decode; bus states wait for ack even if CS rose
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:
        if (csn_fall) state_nxt = S_CMD;
      S_CMD:
        if (i_csn) begin
          state_nxt = S_IDLE;
        end else if (i_rx_valid) begin
          unique case (i_rx_data)
            CMD_STATUS: state_nxt = S_ST_SEND;
`ifdef SPI_BOOT_READBACK_EN
            CMD_READ:   state_nxt = S_RD_COL;
`endif
            CMD_WRITE:  state_nxt = S_WR_COL;
            default:    state_nxt = S_DRAIN;
          endcase
        end
      S_WR_COL:
        if (i_csn) begin
          state_nxt = S_IDLE;
        end else if (asm_done) begin
          if (asm_word_nxt == BOOT_TERM)
            state_nxt = S_DRAIN;
          else if (!idx_full)
            state_nxt = S_WR_BUS;
        end
      S_WR_BUS:
        if (bus.i_mem_ack)
          state_nxt = i_csn ? S_IDLE : S_WR_COL;
`ifdef SPI_BOOT_READBACK_EN
      S_RD_COL:
        if (i_csn)         state_nxt = S_IDLE;
        else if (asm_done) state_nxt = S_RD_BUS;
      S_RD_BUS:
        if (bus.i_mem_ack)
          state_nxt = i_csn ? S_IDLE : S_RD_COL;
`endif
      S_ST_SEND:
        if (i_csn)         state_nxt = S_IDLE;
        else if (asm_done) state_nxt = S_DRAIN;
      S_DRAIN:
        if (i_csn) state_nxt = S_IDLE;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  // bus, tx-load and event strobes per state
  always_comb begin
    bus.o_mem_cyc = 1'b0;
    bus.o_mem_we  = 1'b0;
    bus.o_mem_adr = ADR_W'({word_idx[29:0], 2'b00});
    bus.o_mem_dat = asm_word;
    asm_clr       = (state == S_IDLE);
    tx_load       = 1'b0;
    tx_word       = '0;
    wr_dec        = 1'b0;
    term_hit      = 1'b0;
    full_hit      = 1'b0;
    drop          = 1'b0;
    wr_ack        = 1'b0;
    unique case (state)
      S_CMD:
        if (rx_cmd) begin
          tx_load = 1'b1;
          if (i_rx_data == CMD_STATUS) tx_word = i_status;
          wr_dec = (i_rx_data == CMD_WRITE);
        end
      S_WR_COL:
        if (asm_done) begin
          term_hit = (asm_word_nxt == BOOT_TERM);
          full_hit = !term_hit && idx_full;
        end
      S_WR_BUS: begin
        bus.o_mem_cyc = 1'b1;
        bus.o_mem_we  = 1'b1;
        drop          = i_rx_valid;
        wr_ack        = bus.i_mem_ack;
      end
`ifdef SPI_BOOT_READBACK_EN
      S_RD_BUS: begin
        bus.o_mem_cyc = 1'b1;
        bus.o_mem_adr = ADR_W'(asm_word);
        drop          = i_rx_valid;
        if (bus.i_mem_ack) begin
          tx_load = 1'b1;
          tx_word = bus.i_mem_rdt;
        end
      end
`endif
      default: ;
    endcase
  end

  // session flags, word index and saturating write count
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      csn_q     <= 1'b1;
      word_idx  <= '0;
      word_cnt  <= '0;
      ovr       <= 1'b0;
      boot_done <= 1'b0;
      prog      <= 1'b0;
    end else begin
      csn_q <= i_csn;
      if (wr_dec) begin
        word_idx <= '0;
        prog     <= 1'b1;
      end
      if (state_nxt == S_IDLE) prog <= 1'b0;
      if (wr_ack) begin
        word_idx <= word_idx + 32'd1;
        if (word_cnt != 16'hFFFF)
          word_cnt <= word_cnt + 16'd1;
      end
      if (term_hit) boot_done <= 1'b1;
      if (full_hit || drop) ovr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_boot_ctrl.sv
// tb_spi_boot_ctrl: directed checks of the SPI boot controller
// against a small IMEM model with programmable ack delay.
module tb_spi_boot_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        csn;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [7:0]  tx_data;
  logic [31:0] status;
  logic        prog;
  logic        boot_done;
  logic        ovr;
  logic [15:0] word_cnt;

  int pass  = 0;
  int total = 0;

  spi_boot_ctrl_if #(.ADR_W(32)) bus ();

  spi_boot_ctrl #(
    .IMEM_WORDS (4),
    .ADR_W      (32)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_csn       (csn),
    .i_rx_valid  (rx_valid),
    .i_rx_data   (rx_data),
    .o_tx_data   (tx_data),
    .bus         (bus),
    .i_status    (status),
    .o_prog      (prog),
    .o_boot_done (boot_done),
    .o_ovr       (ovr),
    .o_word_cnt  (word_cnt)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [16];
  logic [31:0] wr_adr [64];
  logic [31:0] wr_dat [64];
  int ack_delay = 0;
  int wait_cnt  = 0;
  int wr_n      = 0;
  int rd_n      = 0;

  // IMEM model: single-cycle ack after ack_delay cycles of cyc
  always @(posedge clk) begin
    bus.i_mem_ack <= 1'b0;
    if (!bus.o_mem_cyc) begin
      wait_cnt <= 0;
    end else if (!bus.i_mem_ack) begin
      if (wait_cnt >= ack_delay) begin
        bus.i_mem_ack <= 1'b1;
        wait_cnt <= 0;
        if (bus.o_mem_we) begin
          mem[bus.o_mem_adr[5:2]] <= bus.o_mem_dat;
          wr_adr[wr_n[5:0]] <= bus.o_mem_adr;
          wr_dat[wr_n[5:0]] <= bus.o_mem_dat;
          wr_n <= wr_n + 1;
        end else begin
          bus.i_mem_rdt <= mem[bus.o_mem_adr[5:2]];
          rd_n <= rd_n + 1;
        end
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    tick(6);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic cs_low;
    @(negedge clk);
    csn = 1'b0;
    tick(2);
  endtask

  task automatic cs_high;
    @(negedge clk);
    csn = 1'b1;
    tick(4);
  endtask

  task automatic wait_writes(input int n);
    int c;
    c = 0;
    while (wr_n < n && c < 200) begin
      @(negedge clk);
      c++;
    end
    total++;
    if (wr_n < n)
      $display("FAIL wait_writes: wr_n=%0d required>=%0d", wr_n, n);
    else pass++;
  endtask

  task automatic test_reset;
    rst = 1'b1; csn = 1'b1; rx_valid = 1'b0;
    rx_data = 8'h00; status = 32'h0;
    tick(3);
    total++; if (bus.o_mem_cyc !== 1'b0) $display("FAIL rst_cyc: got %b want 0", bus.o_mem_cyc); else pass++;
    total++; if (bus.o_mem_we !== 1'b0) $display("FAIL rst_we: got %b want 0", bus.o_mem_we); else pass++;
    total++; if (prog !== 1'b0) $display("FAIL rst_prog: got %b want 0", prog); else pass++;
    total++; if (boot_done !== 1'b0) $display("FAIL rst_done: got %b want 0", boot_done); else pass++;
    total++; if (ovr !== 1'b0) $display("FAIL rst_ovr: got %b want 0", ovr); else pass++;
    total++; if (word_cnt !== 16'd0) $display("FAIL rst_cnt: got %0d want 0", word_cnt); else pass++;
    total++; if (tx_data !== 8'h00) $display("FAIL rst_tx: got %h want 00", tx_data); else pass++;
    @(negedge clk);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_status;
    logic [7:0] exp [4];
    exp[0] = 8'h34; exp[1] = 8'h12;
    exp[2] = 8'h00; exp[3] = 8'h00;
    status = 32'h0000_1234;
    cs_low();
    send_byte(8'h00);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (tx_data !== exp[i])
        $display("FAIL status_tx%0d: got %h want %h", i, tx_data, exp[i]);
      else pass++;
      send_byte(8'hA5);
    end
    total++; if (prog !== 1'b0) $display("FAIL status_prog: got %b want 0", prog); else pass++;
    cs_high();
    total++; if (wr_n !== 0) $display("FAIL status_wr: got %0d want 0", wr_n); else pass++;
  endtask

  task automatic test_write_boot;
    cs_low();
    send_byte(8'h02);
    total++; if (prog !== 1'b1) $display("FAIL wr_prog_on: got %b want 1", prog); else pass++;
    send_word(32'h0000_0013);
    send_word(32'h0010_0093);
    send_word(32'hFFFF_FFFF);
    total++; if (wr_n !== 2) $display("FAIL wr_count: got %0d want 2", wr_n); else pass++;
    total++; if (wr_adr[0] !== 32'h0) $display("FAIL wr_adr0: got %h want 0", wr_adr[0]); else pass++;
    total++; if (wr_dat[0] !== 32'h13) $display("FAIL wr_dat0: got %h want 13", wr_dat[0]); else pass++;
    total++; if (wr_adr[1] !== 32'h4) $display("FAIL wr_adr1: got %h want 4", wr_adr[1]); else pass++;
    total++; if (wr_dat[1] !== 32'h0010_0093) $display("FAIL wr_dat1: got %h want 00100093", wr_dat[1]); else pass++;
    total++; if (word_cnt !== 16'd2) $display("FAIL wr_cnt: got %0d want 2", word_cnt); else pass++;
    total++; if (boot_done !== 1'b1) $display("FAIL wr_done: got %b want 1", boot_done); else pass++;
    total++; if (prog !== 1'b1) $display("FAIL wr_prog_drain: got %b want 1", prog); else pass++;
    cs_high();
    total++; if (prog !== 1'b0) $display("FAIL wr_prog_off: got %b want 0", prog); else pass++;
  endtask

`ifdef SPI_BOOT_READBACK_EN
  task automatic test_readback;
    logic [31:0] got;
    logic [31:0] a4;
    got = '0;
    a4 = 32'h0000_0004;
    cs_low();
    send_byte(8'h01);
    send_word(32'h0);
    for (int i = 0; i < 4; i++) begin
      got[8*i +: 8] = tx_data;
      send_byte(a4[8*i +: 8]);
    end
    total++; if (got !== 32'h13) $display("FAIL rb_data: got %h want 00000013", got); else pass++;
    total++; if (rd_n !== 2) $display("FAIL rb_reads: got %0d want 2", rd_n); else pass++;
    total++; if (wr_n !== 2) $display("FAIL rb_writes: got %0d want 2", wr_n); else pass++;
    cs_high();
  endtask
`else
  task automatic test_readback;
    cs_low();
    send_byte(8'h01);
    send_word(32'h0);
    send_word(32'h4);
    total++; if (rd_n !== 0) $display("FAIL rb_off_reads: got %0d want 0", rd_n); else pass++;
    total++; if (wr_n !== 2) $display("FAIL rb_off_writes: got %0d want 2", wr_n); else pass++;
    total++; if (tx_data !== 8'h00) $display("FAIL rb_off_tx: got %h want 00", tx_data); else pass++;
    cs_high();
  endtask
`endif

  task automatic test_partial;
    cs_low();
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    cs_high();
    total++; if (wr_n !== 2) $display("FAIL part_wr: got %0d want 2", wr_n); else pass++;
    total++; if (word_cnt !== 16'd2) $display("FAIL part_cnt: got %0d want 2", word_cnt); else pass++;
    total++; if (prog !== 1'b0) $display("FAIL part_prog: got %b want 0", prog); else pass++;
    cs_low();
    send_byte(8'h02);
    send_word(32'hAABB_CCDD);
    total++; if (wr_n !== 3) $display("FAIL part_next_wr: got %0d want 3", wr_n); else pass++;
    total++; if (wr_adr[2] !== 32'h0) $display("FAIL part_next_adr: got %h want 0", wr_adr[2]); else pass++;
    total++; if (wr_dat[2] !== 32'hAABB_CCDD) $display("FAIL part_next_dat: got %h want aabbccdd", wr_dat[2]); else pass++;
    total++; if (word_cnt !== 16'd3) $display("FAIL part_next_cnt: got %0d want 3", word_cnt); else pass++;
    cs_high();
  endtask

  task automatic test_ack_delay;
    total++; if (ovr !== 1'b0) $display("FAIL ack_ovr_pre: got %b want 0", ovr); else pass++;
    ack_delay = 40;
    cs_low();
    send_byte(8'h02);
    send_word(32'h1122_3344);
    send_byte(8'h55);
    total++; if (ovr !== 1'b1) $display("FAIL ack_ovr: got %b want 1", ovr); else pass++;
    total++; if (wr_n !== 3) $display("FAIL ack_pending: got %0d want 3", wr_n); else pass++;
    wait_writes(4);
    tick(2);
    ack_delay = 0;
    total++; if (wr_dat[3] !== 32'h1122_3344) $display("FAIL ack_dat: got %h want 11223344", wr_dat[3]); else pass++;
    send_word(32'h6677_8899);
    total++; if (wr_n !== 5) $display("FAIL ack_next_wr: got %0d want 5", wr_n); else pass++;
    total++; if (wr_adr[4] !== 32'h4) $display("FAIL ack_next_adr: got %h want 4", wr_adr[4]); else pass++;
    total++; if (wr_dat[4] !== 32'h6677_8899) $display("FAIL ack_next_dat: got %h want 66778899", wr_dat[4]); else pass++;
    total++; if (word_cnt !== 16'd5) $display("FAIL ack_cnt: got %0d want 5", word_cnt); else pass++;
    cs_high();
  endtask

  task automatic test_overflow;
    @(negedge clk); rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    total++; if (ovr !== 1'b0) $display("FAIL ovf_rst_ovr: got %b want 0", ovr); else pass++;
    total++; if (word_cnt !== 16'd0) $display("FAIL ovf_rst_cnt: got %0d want 0", word_cnt); else pass++;
    cs_low();
    send_byte(8'h02);
    for (int k = 0; k < 5; k++) send_word(32'h100 + 32'(k));
    total++; if (wr_n !== 9) $display("FAIL ovf_wr: got %0d want 9", wr_n); else pass++;
    total++; if (wr_adr[8] !== 32'hC) $display("FAIL ovf_adr: got %h want c", wr_adr[8]); else pass++;
    total++; if (wr_dat[8] !== 32'h103) $display("FAIL ovf_dat: got %h want 103", wr_dat[8]); else pass++;
    total++; if (ovr !== 1'b1) $display("FAIL ovf_ovr: got %b want 1", ovr); else pass++;
    total++; if (word_cnt !== 16'd4) $display("FAIL ovf_cnt: got %0d want 4", word_cnt); else pass++;
    cs_high();
  endtask

  task automatic test_reset_bus;
    ack_delay = 1000;
    cs_low();
    send_byte(8'h02);
    send_word(32'hDEAD_BEEF);
    total++; if (bus.o_mem_cyc !== 1'b1) $display("FAIL rbus_cyc_on: got %b want 1", bus.o_mem_cyc); else pass++;
    @(negedge clk);
    rst = 1'b1;
    csn = 1'b1;
    @(negedge clk);
    total++; if (bus.o_mem_cyc !== 1'b0) $display("FAIL rbus_cyc_off: got %b want 0", bus.o_mem_cyc); else pass++;
    total++; if (bus.o_mem_we !== 1'b0) $display("FAIL rbus_we_off: got %b want 0", bus.o_mem_we); else pass++;
    total++; if (prog !== 1'b0) $display("FAIL rbus_prog: got %b want 0", prog); else pass++;
    rst = 1'b0;
    ack_delay = 0;
    tick(4);
    total++; if (wr_n !== 9) $display("FAIL rbus_wr: got %0d want 9", wr_n); else pass++;
  endtask

  initial begin
    test_reset();
    test_status();
    test_write_boot();
    test_readback();
    test_partial();
    test_ack_delay();
    test_overflow();
    test_reset_bus();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule

// File: doc/spi_boot_ctrl.md
SPI_BOOT_CTRL -- requirements
Module: spi_boot_ctrl

Interface
REQ-001 SHALL have parameter IMEM_WORDS, default 1024, the IMEM depth in 32-bit words.
REQ-002 SHALL have parameter ADR_W, default 32, the width of the bus byte address.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port i_rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port i_csn, input, 1 bit: SPI chip select, already synchronised, active-low level.
REQ-006 SHALL have ports i_rx_valid (input, 1 bit) and i_rx_data (input, 8 bits): a one-cycle strobe carrying a byte received from the SPI slave shifter.
REQ-007 SHALL have port o_tx_data, output, 8 bits: the byte the slave shifts out on the next transfer.
REQ-008 SHALL have the bus master ports o_mem_cyc (1), o_mem_we (1), o_mem_adr (ADR_W), o_mem_dat (32), i_mem_rdt (32) and i_mem_ack (1).
REQ-009 SHALL have port i_status, input, 32 bits: the measurement result register (tau).
REQ-010 SHALL have port o_prog, output, 1 bit: holds the CPU in reset while a write session is active.
REQ-011 SHALL have port o_boot_done, output, 1 bit: a sticky flag set when the terminator word is received.
REQ-012 SHALL have ports o_ovr (output, 1 bit), a sticky byte-overrun or IMEM-overflow flag, and o_word_cnt (output, 16 bits), the number of words written, saturating.

Function
REQ-013 SHALL use the states IDLE, CMD, WR_COL, WR_BUS, RD_COL, RD_BUS, ST_SEND and DRAIN.
REQ-014 SHALL leave IDLE for CMD when i_csn falls; the first byte received in CMD is the command and selects the next state: 0x00 goes to ST_SEND, 0x01 goes to RD_COL, 0x02 goes to WR_COL, and any other value goes to DRAIN.
REQ-015 SHALL, in ST_SEND, latch i_status at command decode and drive it on o_tx_data over the next 4 transfers, least-significant byte first, ignoring the received bytes.
REQ-016 SHALL, in WR_COL, assemble 4 bytes least-significant first into a word and then enter WR_BUS, unless the word is 0xFFFFFFFF.
REQ-017 SHALL, on a 0xFFFFFFFF word, perform no write, set o_boot_done and enter DRAIN.
REQ-018 SHALL, in WR_BUS, assert o_mem_cyc and o_mem_we with o_mem_adr equal to word_index*4 and hold them until i_mem_ack, then increment word_index and o_word_cnt and return to WR_COL; the bus cycle begins on the cycle after the 4th byte.
REQ-019 SHALL, when word_index is at or above IMEM_WORDS, drop the write, set o_ovr and keep collecting.
REQ-020 SHALL, in RD_COL, assemble a 4-byte address, issue a bus read in RD_BUS, and load i_mem_rdt into the tx buffer; the returned word is shifted out during the next 4-byte address transfer, giving a read latency of one word.
REQ-021 SHALL update o_tx_data within 1 cycle of each i_rx_valid.
REQ-022 SHALL, on an i_rx_valid while in WR_BUS or RD_BUS, drop the byte and set o_ovr.
REQ-023 SHALL, on i_csn rising, discard any partial word, finish an outstanding bus cycle (hold until ack) and then enter IDLE.
REQ-024 SHALL, in DRAIN, ignore all bytes until i_csn rises.
REQ-025 SHALL assert o_prog from 0x02 decode until IDLE is re-entered.
REQ-026 SHALL reset word_index to 0 at each 0x02 command.

Reset
REQ-027 SHALL, under i_rst, enter IDLE and clear o_mem_cyc, o_mem_we, o_prog, o_boot_done, o_ovr, o_word_cnt and word_index, and set o_tx_data to 0x00; i_rst overrides any bus cycle in flight.

Configuration
REQ-028 SHALL, with SPI_BOOT_READBACK_EN defined, implement command 0x01 as RD_COL/RD_BUS.
REQ-029 SHALL, without SPI_BOOT_READBACK_EN defined, decode 0x01 to DRAIN, omit the RD states, and never assert o_mem_cyc with o_mem_we low.

Structure
REQ-030 SHALL place the command codes (0x00, 0x01, 0x02), the terminator 0xFFFFFFFF and the state encoding in the shared package spi_boot_pkg.
REQ-031 SHALL use one sub-module, spi_word_asm, a 4-byte LSB-first assembler/serialiser with a byte counter.

Verification
REQ-032 SHALL check: CS low, 0x02, words 0x00000013 and 0x00100093, then 0xFFFFFFFF -> two writes at addresses 0x0 and 0x4, o_word_cnt=2, o_boot_done=1, o_prog low after CS high.
REQ-033 SHALL check: 0x01 followed by addresses 0x0 and 0x4 -> the second transfer returns 0x00000013 on MISO (requires SPI_BOOT_READBACK_EN).
REQ-034 SHALL check: i_status=0x00001234, command 0x00 -> tx bytes 0x34, 0x12, 0x00, 0x00.
REQ-035 SHALL check: CS rises after 2 of 4 write bytes -> no write, IDLE, o_word_cnt unchanged.
REQ-036 SHALL check: i_mem_ack delayed 40 cycles while a byte arrives -> byte dropped, o_ovr=1, the write completes.
REQ-037 SHALL check: IMEM_WORDS=4 and 5 words written -> 4 writes, o_ovr=1; i_rst mid-WR_BUS -> o_mem_cyc=0 on the next cycle.
